// File: rtl/benes_8_fabric.sv
// ---------------------------------------------------------------------------
// benes_8_fabric
// Routes eight W-bit words through a 5-stage, 8-input Benes network of 2x2
// switches. The 20-bit switch-setting word comes from Benes_8 `state`.
// There is one register slot per switch stage. Each beat carries the
// switch settings it still needs, so a new configuration never disturbs
// beats that are already in the pipe.
//
// Ports
//   clk         clock, rising edge
//   areset      asynchronous reset, active low
//   cfg_valid   cfg_state is valid; loads cfg_active at the edge
//   cfg_ready   always 1
//   cfg_state   20-bit switch settings; stage s, switch j -> bit 19-4s-j
//   in_valid    in_data holds a beat
//   in_ready    fabric can accept a beat (low only while the output stalls)
//   in_data     8 words; word i = in_data[W*i +: W]
//   out_valid   out_data holds a routed beat
//   out_ready   consumer accepts the beat
//   out_data    routed words; word k = out_data[W*k +: W]
//   cfg_active  configuration the next accepted beat will use
// ---------------------------------------------------------------------------
module benes_8_fabric #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           areset,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [19:0]    cfg_state,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [8*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [8*W-1:0] out_data,
    output logic [19:0]    cfg_active
);

    localparam int DW = 8 * W;

    // A 2x2 switch on one word pair: the low word is in0, the high word is in1.
    function automatic logic [2*W-1:0] sw2(input logic [2*W-1:0] p, input logic x);
        return x ? {p[W-1:0], p[2*W-1:W]} : p;
    endfunction

    // One column of four switches. Switch j sits on words 2j/2j+1 and is
    // steered by ctl[3-j], because the cfg nibble holds switch 0 in its MSB.
    function automatic logic [DW-1:0] switch_stage(input logic [DW-1:0] d,
                                                   input logic [3:0]    ctl);
        return {sw2(d[W*6 +: 2*W], ctl[0]), sw2(d[W*4 +: 2*W], ctl[1]),
                sw2(d[W*2 +: 2*W], ctl[2]), sw2(d[W*0 +: 2*W], ctl[3])};
    endfunction

    // After stage 0: position 2j -> j, position 2j+1 -> 4+j.
    function automatic logic [DW-1:0] wire_unshuffle(input logic [DW-1:0] d);
        return {d[W*7 +: W], d[W*5 +: W], d[W*3 +: W], d[W*1 +: W],
                d[W*6 +: W], d[W*4 +: W], d[W*2 +: W], d[W*0 +: W]};
    endfunction

    // After stages 1 and 2: inside each half, the middle two lines swap.
    function automatic logic [DW-1:0] wire_mid(input logic [DW-1:0] d);
        return {d[W*7 +: W], d[W*5 +: W], d[W*6 +: W], d[W*4 +: W],
                d[W*3 +: W], d[W*1 +: W], d[W*2 +: W], d[W*0 +: W]};
    endfunction

    // After stage 3: position j -> 2j, position 4+j -> 2j+1.
    function automatic logic [DW-1:0] wire_shuffle(input logic [DW-1:0] d);
        return {d[W*7 +: W], d[W*3 +: W], d[W*6 +: W], d[W*2 +: W],
                d[W*5 +: W], d[W*1 +: W], d[W*4 +: W], d[W*0 +: W]};
    endfunction

    logic [19:0]   cfg_active_q, cfg_active_d;
    logic          s0_valid_q, s0_valid_d;
    logic          s1_valid_q, s1_valid_d;
    logic          s2_valid_q, s2_valid_d;
    logic          s3_valid_q, s3_valid_d;
    logic          s4_valid_q, s4_valid_d;
    logic [DW-1:0] s0_data_q, s0_data_d;
    logic [DW-1:0] s1_data_q, s1_data_d;
    logic [DW-1:0] s2_data_q, s2_data_d;
    logic [DW-1:0] s3_data_q, s3_data_d;
    logic [DW-1:0] s4_data_q, s4_data_d;
    // The settings still ahead of each slot. The next stage's nibble is
    // always in the top four bits.
    logic [15:0]   s0_cfg_q, s0_cfg_d;
    logic [11:0]   s1_cfg_q, s1_cfg_d;
    logic [7:0]    s2_cfg_q, s2_cfg_d;
    logic [3:0]    s3_cfg_q, s3_cfg_d;
    logic          stall;

    assign stall      = s4_valid_q & ~out_ready;
    assign in_ready   = ~stall;
    assign cfg_ready  = 1'b1;
    assign out_valid  = s4_valid_q;
    assign out_data   = s4_data_q;
    assign cfg_active = cfg_active_q;

    always_comb begin
        // The configuration loads independently of the stall.
        cfg_active_d = cfg_valid ? cfg_state : cfg_active_q;

        s0_valid_d = s0_valid_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        s3_valid_d = s3_valid_q;
        s4_valid_d = s4_valid_q;
        s0_data_d  = s0_data_q;
        s1_data_d  = s1_data_q;
        s2_data_d  = s2_data_q;
        s3_data_d  = s3_data_q;
        s4_data_d  = s4_data_q;
        s0_cfg_d   = s0_cfg_q;
        s1_cfg_d   = s1_cfg_q;
        s2_cfg_d   = s2_cfg_q;
        s3_cfg_d   = s3_cfg_q;

        if (!stall) begin
            // Not stalled means in_ready=1, so in_valid alone marks an accept.
            // An idle cycle shifts a bubble into S0.
            s0_valid_d = in_valid;
            s0_data_d  = wire_unshuffle(switch_stage(in_data, cfg_active_q[19:16]));
            s0_cfg_d   = cfg_active_q[15:0];

            s1_valid_d = s0_valid_q;
            s1_data_d  = wire_mid(switch_stage(s0_data_q, s0_cfg_q[15:12]));
            s1_cfg_d   = s0_cfg_q[11:0];

            s2_valid_d = s1_valid_q;
            s2_data_d  = wire_mid(switch_stage(s1_data_q, s1_cfg_q[11:8]));
            s2_cfg_d   = s1_cfg_q[7:0];

            s3_valid_d = s2_valid_q;
            s3_data_d  = wire_shuffle(switch_stage(s2_data_q, s2_cfg_q[7:4]));
            s3_cfg_d   = s2_cfg_q[3:0];

            s4_valid_d = s3_valid_q;
            s4_data_d  = switch_stage(s3_data_q, s3_cfg_q);
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            cfg_active_q <= '0;
            s0_valid_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s3_valid_q   <= 1'b0;
            s4_valid_q   <= 1'b0;
            s0_data_q    <= '0;
            s1_data_q    <= '0;
            s2_data_q    <= '0;
            s3_data_q    <= '0;
            s4_data_q    <= '0;
            s0_cfg_q     <= '0;
            s1_cfg_q     <= '0;
            s2_cfg_q     <= '0;
            s3_cfg_q     <= '0;
        end else begin
            cfg_active_q <= cfg_active_d;
            s0_valid_q   <= s0_valid_d;
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            s3_valid_q   <= s3_valid_d;
            s4_valid_q   <= s4_valid_d;
            s0_data_q    <= s0_data_d;
            s1_data_q    <= s1_data_d;
            s2_data_q    <= s2_data_d;
            s3_data_q    <= s3_data_d;
            s4_data_q    <= s4_data_d;
            s0_cfg_q     <= s0_cfg_d;
            s1_cfg_q     <= s1_cfg_d;
            s2_cfg_q     <= s2_cfg_d;
            s3_cfg_q     <= s3_cfg_d;
        end
    end

endmodule

// File: tb/tb_benes_8_fabric.sv
module tb_benes_8_fabric;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           areset = 1'b0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [19:0]    cfg_state = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [8*W-1:0] in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [8*W-1:0] out_data;
    logic [19:0]    cfg_active;

    int n_vec = 0;
    int n_err = 0;

    // Reference: a beat's routed result is computed once, when it is accepted.
    // It then moves through a 5-deep delay line that freezes on a stall.
    bit          m_valid [5];
    logic [63:0] m_data  [5];
    logic [19:0] m_cfg;

    always #5 clk = ~clk;

    benes_8_fabric #(.W(W)) dut (
        .clk        (clk),
        .areset     (areset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_state  (cfg_state),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_active (cfg_active)
    );

    // Follows each input word's line position through the network by rule.
    function automatic logic [63:0] model_route(input logic [63:0] d, input logic [19:0] cfg);
        logic [63:0] o;
        o = '0;
        for (int i = 0; i < 8; i++) begin
            int p;
            p = i;
            for (int s = 0; s < 5; s++) begin
                if (cfg[19 - 4*s - p/2]) p = p ^ 1;
                case (s)
                    0:       p = p/2 + 4*(p%2);
                    1, 2:    p = (p/4)*4 + 2*(p%2) + (p/2)%2;
                    3:       p = 2*(p%4) + p/4;
                    default: ;
                endcase
            end
            o[8*p +: 8] = d[8*i +: 8];
        end
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
        end
        m_cfg = '0;
    endtask

    // Applies the current inputs at the next rising edge, updates the model,
    // and returns 1 time unit after that edge.
    task automatic clk_cycle();
        bit          stall;
        logic [63:0] routed;
        stall  = m_valid[4] && !out_ready;
        routed = model_route(in_data, m_cfg);
        @(posedge clk);
        if (!stall) begin
            for (int k = 4; k > 0; k--) begin
                m_valid[k] = m_valid[k-1];
                m_data[k]  = m_data[k-1];
            end
            m_valid[0] = in_valid;
            m_data[0]  = routed;
        end
        if (cfg_valid) m_cfg = cfg_state;
        #1;
    endtask

    task automatic test_reset();
        areset = 1'b0;
        #2;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset.out_valid got %0b exp 0", out_valid); end
        n_vec++; if (out_data !== 64'h0) begin n_err++; $display("FAIL reset.out_data got %h exp 0", out_data); end
        n_vec++; if (cfg_active !== 20'h0) begin n_err++; $display("FAIL reset.cfg_active got %h exp 0", cfg_active); end
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset.cfg_ready got %0b exp 1", cfg_ready); end
        @(posedge clk); #1;
        areset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset.in_ready got %0b exp 1", in_ready); end
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset.cfg_ready_post got %0b exp 1", cfg_ready); end
    endtask

    task automatic test_identity();
        for (int i = 0; i < 8; i++) in_data[8*i +: 8] = 8'h10 + 8'(i);
        in_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            clk_cycle();
            in_valid = 1'b0;
            n_vec++; if (out_valid !== m_valid[4]) begin n_err++; $display("FAIL ident.out_valid cyc %0d got %0b exp %0b", c, out_valid, m_valid[4]); end
            if (m_valid[4]) begin n_vec++; if (out_data !== m_data[4]) begin n_err++; $display("FAIL ident.out_data cyc %0d got %h exp %h", c, out_data, m_data[4]); end end
            if (c == 4) begin
                n_vec++; if (out_valid !== 1'b1 || out_data !== 64'h1716151413121110) begin n_err++; $display("FAIL ident.latency got v=%0b %h exp v=1 1716151413121110", out_valid, out_data); end
            end
        end
    endtask

    task automatic test_cfg_cross();
        for (int c = 0; c < 10; c++) begin
            cfg_valid = 1'b0; in_valid = 1'b0;
            case (c)
                0: begin cfg_valid = 1'b1; cfg_state = 20'hF0000; end
                1, 3: begin in_valid = 1'b1; in_data = 64'h0706050403020100; end
                2: begin cfg_valid = 1'b1; cfg_state = 20'hF000F; end
                default: ;
            endcase
            clk_cycle();
            n_vec++; if (out_valid !== m_valid[4]) begin n_err++; $display("FAIL cross.out_valid cyc %0d got %0b exp %0b", c, out_valid, m_valid[4]); end
            if (m_valid[4]) begin n_vec++; if (out_data !== m_data[4]) begin n_err++; $display("FAIL cross.out_data cyc %0d got %h exp %h", c, out_data, m_data[4]); end end
            n_vec++; if (cfg_active !== m_cfg) begin n_err++; $display("FAIL cross.cfg_active cyc %0d got %h exp %h", c, cfg_active, m_cfg); end
            if (c == 5) begin n_vec++; if (out_data !== 64'h0607040502030001) begin n_err++; $display("FAIL cross.f0000 got %h exp 0607040502030001", out_data); end end
            if (c == 7) begin n_vec++; if (out_data !== 64'h0706050403020100) begin n_err++; $display("FAIL cross.f000f got %h exp 0706050403020100", out_data); end end
        end
    endtask

    task automatic test_random_perm();
        for (int c = 0; c < 70; c++) begin
            cfg_valid = 1'b0; in_valid = 1'b0;
            if (c < 60) begin
                if (c % 2 == 0) begin cfg_valid = 1'b1; cfg_state = 20'($urandom_range(0, 20'hFFFFF)); end
                else begin in_valid = 1'b1; in_data = 64'h0706050403020100; end
            end
            clk_cycle();
            n_vec++; if (out_valid !== m_valid[4]) begin n_err++; $display("FAIL perm.out_valid cyc %0d got %0b exp %0b", c, out_valid, m_valid[4]); end
            if (m_valid[4]) begin
                logic [7:0] seen;
                seen = '0;
                for (int k = 0; k < 8; k++) if (out_data[8*k +: 8] < 8) seen[out_data[8*k +: 3]] = 1'b1;
                n_vec++; if (out_data !== m_data[4]) begin n_err++; $display("FAIL perm.out_data cyc %0d got %h exp %h", c, out_data, m_data[4]); end
                n_vec++; if (seen !== 8'hFF) begin n_err++; $display("FAIL perm.bijective cyc %0d got %h exp ff", c, seen); end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 9; c++) begin
            cfg_valid = 1'b0; in_valid = 1'b0;
            case (c)
                0: begin cfg_valid = 1'b1; cfg_state = 20'h00000; end
                1: begin in_valid = 1'b1; in_data = 64'h0123456789abcdef; end
                2: begin in_valid = 1'b1; in_data = 64'hfedcba9876543210; cfg_valid = 1'b1; cfg_state = 20'hF0000; end
                3: begin in_valid = 1'b1; in_data = 64'h1122334455667788; end
                default: ;
            endcase
            clk_cycle();
            n_vec++; if (out_valid !== m_valid[4]) begin n_err++; $display("FAIL b2b.out_valid cyc %0d got %0b exp %0b", c, out_valid, m_valid[4]); end
            if (m_valid[4]) begin n_vec++; if (out_data !== m_data[4]) begin n_err++; $display("FAIL b2b.out_data cyc %0d got %h exp %h", c, out_data, m_data[4]); end end
            if (c == 5) begin n_vec++; if (out_valid !== 1'b1 || out_data !== 64'h0123456789abcdef) begin n_err++; $display("FAIL b2b.beat_a got v=%0b %h exp v=1 0123456789abcdef", out_valid, out_data); end end
            if (c == 6) begin n_vec++; if (out_valid !== 1'b1 || out_data !== 64'hfedcba9876543210) begin n_err++; $display("FAIL b2b.beat_b got v=%0b %h exp v=1 fedcba9876543210", out_valid, out_data); end end
            if (c == 7) begin n_vec++; if (out_valid !== 1'b1 || out_data !== 64'h2211443366558877) begin n_err++; $display("FAIL b2b.beat_c got v=%0b %h exp v=1 2211443366558877", out_valid, out_data); end end
        end
    endtask

    task automatic test_stall();
        int          drained;
        logic [63:0] held;
        drained = 0;
        held    = '0;
        for (int c = 0; c < 17; c++) begin
            cfg_valid = 1'b0;
            in_data   = {$urandom, $urandom};
            in_valid  = (c < 11);
            out_ready = (c >= 11);
            if (out_valid && out_ready) drained++;
            clk_cycle();
            n_vec++; if (out_valid !== m_valid[4]) begin n_err++; $display("FAIL stall.out_valid cyc %0d got %0b exp %0b", c, out_valid, m_valid[4]); end
            if (m_valid[4]) begin n_vec++; if (out_data !== m_data[4]) begin n_err++; $display("FAIL stall.out_data cyc %0d got %h exp %h", c, out_data, m_data[4]); end end
            n_vec++; if (in_ready !== !(m_valid[4] && !out_ready)) begin n_err++; $display("FAIL stall.in_ready cyc %0d got %0b exp %0b", c, in_ready, !(m_valid[4] && !out_ready)); end
            if (c == 4) held = m_data[4];
            if (c >= 4 && c <= 10) begin
                n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held) begin n_err++; $display("FAIL stall.hold cyc %0d got v=%0b rdy=%0b %h exp v=1 rdy=0 %h", c, out_valid, in_ready, out_data, held); end
            end
        end
        out_ready = 1'b1;
        n_vec++; if (drained != 5) begin n_err++; $display("FAIL stall.drain_count got %0d exp 5", drained); end
    endtask

    task automatic test_reset_midstream();
        for (int c = 0; c < 7; c++) begin
            cfg_valid = (c == 0);
            cfg_state = 20'hF0000;
            in_valid  = (c > 0);
            in_data   = {$urandom, $urandom};
            clk_cycle();
        end
        n_vec++; if (out_valid !== 1'b1 || out_data !== m_data[4]) begin n_err++; $display("FAIL rstmid.pre got v=%0b %h exp v=1 %h", out_valid, out_data, m_data[4]); end
        #2;
        areset = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid.out_valid got %0b exp 0", out_valid); end
        n_vec++; if (out_data !== 64'h0) begin n_err++; $display("FAIL rstmid.out_data got %h exp 0", out_data); end
        n_vec++; if (cfg_active !== 20'h0) begin n_err++; $display("FAIL rstmid.cfg_active got %h exp 0", cfg_active); end
        model_reset();
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        @(posedge clk); #1;
        areset = 1'b1;
        for (int c = 0; c < 7; c++) begin
            clk_cycle();
            n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || cfg_active !== 20'h0) begin n_err++; $display("FAIL rstmid.post cyc %0d got v=%0b rdy=%0b cfg=%h exp v=0 rdy=1 cfg=0", c, out_valid, in_ready, cfg_active); end
        end
    endtask

    task automatic test_random_stream();
        for (int c = 0; c < 320; c++) begin
            if (c < 300) begin
                in_valid  = ($urandom_range(0, 99) < 70);
                out_ready = ($urandom_range(0, 99) < 70);
                cfg_valid = ($urandom_range(0, 99) < 15);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1; cfg_valid = 1'b0;
            end
            cfg_state = 20'($urandom_range(0, 20'hFFFFF));
            in_data   = {$urandom, $urandom};
            clk_cycle();
            n_vec++; if (out_valid !== m_valid[4]) begin n_err++; $display("FAIL stream.out_valid cyc %0d got %0b exp %0b", c, out_valid, m_valid[4]); end
            if (m_valid[4]) begin n_vec++; if (out_data !== m_data[4]) begin n_err++; $display("FAIL stream.out_data cyc %0d got %h exp %h", c, out_data, m_data[4]); end end
            n_vec++; if (in_ready !== !(m_valid[4] && !out_ready)) begin n_err++; $display("FAIL stream.in_ready cyc %0d got %0b exp %0b", c, in_ready, !(m_valid[4] && !out_ready)); end
            n_vec++; if (cfg_active !== m_cfg) begin n_err++; $display("FAIL stream.cfg_active cyc %0d got %h exp %h", c, cfg_active, m_cfg); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_identity();
        test_cfg_cross();
        test_random_perm();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
